mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store front-end sitting directly upstream of DataMem. Takes a byte-addressed RV32I memory request from the datapath (funct3 plus byte address) and drives DataMem's word-only port (6-bit word address, 32-bit data). Handles byte/halfword extraction with sign or zero extension. Performs read-modify-write for SB/SH. Flags misaligned or illegal accesses. Stalls the core via busy until the access completes.

Parameters:
WORD_ADDR_W, 6, DataMem word-address width; byte address width is WORD_ADDR_W+2.
DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request strobe, sampled in IDLE only
req_we  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
addr  in  8  byte address
wdata  in  32  store data, right-justified
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result
misaligned  out  1  error flag, valid with done
dm_read  out  1  to DataMem MemRead
dm_write  out  1  to DataMem MemWrite
dm_addr  out  6  to DataMem addr (word address)
dm_wdata  out  32  to DataMem data_in
dm_rdata  in  32  from DataMem data_out

Behaviour:
- DataMem contract: data_out is combinational from addr while MemRead=1. A write commits on the rising clk edge while MemWrite=1.
- States: IDLE, LOAD, RMW_RD, RMW_WR, WR, RESP.
- IDLE, on req_valid=1: latch funct3, addr, wdata, req_we, then decode:
  - Illegal code -> RESP with error. Legal loads are 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores are 000 SB, 001 SH, 010 SW.
  - Misaligned -> RESP with error. Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Legal load -> LOAD. SW -> WR. SB/SH -> RMW_RD.
- LOAD: dm_read=1. On the edge, register the extracted and extended value into rdata, then -> RESP.
- RMW_RD: dm_read=1. On the edge, capture dm_rdata into the merge register, then -> RMW_WR.
- RMW_WR: dm_write=1. dm_wdata = merge register with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]. -> RESP.
- WR: dm_write=1, dm_wdata=wdata. -> RESP.
- RESP: done=1 for exactly one cycle. misaligned=1 only if the request errored. -> IDLE.
- Lanes are little-endian. Byte offset 0 = bits 7:0. Halfword offset 2 = bits 31:16.
- Extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- rdata updates only on a successful load and holds otherwise. Errors and stores leave rdata unchanged.
- Latency from accept edge to done high:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- dm_addr = latched addr[7:2] in LOAD/RMW_RD/RMW_WR/WR, and 0 in IDLE/RESP.
- dm_read and dm_write are mutually exclusive, decoded from state only. Both are 0 in IDLE/RESP.
- An error never asserts dm_read or dm_write.
- req_valid while busy=1 is ignored; it is not queued. The requester holds or re-issues after done.
- Reset, asynchronous assertion:
  - State -> IDLE immediately.
  - busy, done, misaligned, dm_read, dm_write = 0; dm_addr, dm_wdata = 0; rdata = 0.
  - Reset asserted in RMW_RD or RMW_WR before the write edge prevents the write, leaving memory unchanged.
- Back-to-back: a new request is accepted in the IDLE cycle following RESP. Minimum spacing is latency+1.

Test Plan:
1. rst_n=0 mid-stream -> every output 0 within the same cycle. After release, busy=0 and rdata=0x00000000.
2. SW addr=0x38, wdata=0x0000006E -> one cycle with dm_write=1, dm_addr=14, dm_wdata=0x6E, done 2 cycles after accept. Then LW 0x38 -> rdata=0x0000006E.
3. Word 2 preloaded 0x80FF7F01:
   - LB 0x09 -> 0x0000007F.
   - LB 0x0A -> 0xFFFFFFFF.
   - LBU 0x0B -> 0x00000080.
   - LH 0x0A -> 0xFFFF80FF.
   - LHU 0x0A -> 0x000080FF.
4. Word 3 = 0x11223344:
   - SB 0x0E, wdata=0xDEADBEAB -> one dm_read cycle, then dm_write with dm_wdata=0x11AB3344, done 3 cycles after accept.
   - Then SH 0x0C, wdata=0x0000CAFE -> word 3 = 0x11ABCAFE.
5. LW 0x06, SH 0x03, funct3=011 load -> done after 1 cycle with misaligned=1. dm_read and dm_write stay 0 throughout; rdata unchanged.
6. SB accepted, rst_n pulsed low during RMW_RD -> no dm_write, target word unchanged, busy=0. A req_valid pulse issued while busy produces no extra done.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-addressed RV32I load/store front-end for a word-only data memory.
// Handles lane extraction/extension, read-modify-write for SB/SH and misalignment errors.
module mem_access_unit #(
    parameter int unsigned WORD_ADDR_W = 6,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               funct3,
    input  logic [WORD_ADDR_W+1:0]   addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     misaligned,
    output logic                     dm_read,
    output logic                     dm_write,
    output logic [WORD_ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]        dm_wdata,
    input  logic [DATA_W-1:0]        dm_rdata
);

    localparam int unsigned AW = WORD_ADDR_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StRmwWr,
        StWr,
        StResp
    } state_e;

    state_e      state;
    logic [2:0]  f3_q;
    logic [1:0]  offs_q;
    logic [15:0] wdata_q;

    logic              legal;
    logic              misal;
    logic              err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merge_val;

    // Request decode, evaluated on the raw inputs in IDLE.
    always_comb begin
        legal = 1'b0;
        misal = 1'b0;
        if (req_we) begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (funct3[1:0])
            2'b01:   misal = addr[0];
            2'b10:   misal = |addr[1:0];
            default: misal = 1'b0;
        endcase
        err = !legal || misal;
    end

    // Lane extraction for loads and lane replacement for SB/SH, both from the latched request.
    always_comb begin
        byte_sel = dm_rdata[{offs_q, 3'b000} +: 8];
        half_sel = offs_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_val = dm_rdata;
        endcase
        merge_val = dm_rdata;
        if (f3_q[0]) begin
            merge_val[{offs_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merge_val[{offs_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            f3_q       <= 3'b000;
            offs_q     <= 2'b00;
            wdata_q    <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= '0;
            dm_read    <= 1'b0;
            dm_write   <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        f3_q    <= funct3;
                        offs_q  <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        busy    <= 1'b1;
                        if (err) begin
                            state      <= StResp;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (!req_we) begin
                            state   <= StLoad;
                            dm_read <= 1'b1;
                            dm_addr <= addr[AW-1:2];
                        end else if (funct3 == 3'b010) begin
                            state    <= StWr;
                            dm_write <= 1'b1;
                            dm_wdata <= wdata;
                            dm_addr  <= addr[AW-1:2];
                        end else begin
                            state   <= StRmwRd;
                            dm_read <= 1'b1;
                            dm_addr <= addr[AW-1:2];
                        end
                    end
                end
                StLoad: begin
                    rdata   <= load_val;
                    dm_read <= 1'b0;
                    dm_addr <= '0;
                    done    <= 1'b1;
                    state   <= StResp;
                end
                StRmwRd: begin
                    dm_read  <= 1'b0;
                    dm_write <= 1'b1;
                    dm_wdata <= merge_val;
                    state    <= StRmwWr;
                end
                StRmwWr, StWr: begin
                    dm_write <= 1'b0;
                    dm_wdata <= '0;
                    dm_addr  <= '0;
                    done     <= 1'b1;
                    state    <= StResp;
                end
                StResp: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
